// File: rtl/quad_encoder.sv
// quad_encoder
// Front end for a panel rotary encoder with an integrated push switch.
// The two quadrature phases and the switch are synchronised and
// glitch-filtered. Each valid quadrature step becomes a one-clock count
// strobe plus a direction flag. The switch becomes a debounced level.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst_n  - asynchronous active-low reset
//   ina    - encoder phase A, asynchronous pin
//   inb    - encoder phase B, asynchronous pin
//   sw     - push switch, asynchronous pin, active-high
//   sw_out - debounced switch level
//   dir    - direction of the most recent valid step (1 = A leads B)
//   cnt    - one-clock strobe per valid quadrature step
module quad_encoder #(
  parameter int FILT_CYCLES  = 3,
  parameter int SW_DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ina,
  input  logic inb,
  input  logic sw,
  output logic sw_out,
  output logic dir,
  output logic cnt
);

  localparam int FW  = 4;
  localparam int SWW = $clog2(SW_DB_CYCLES + 1);
  localparam logic [FW-1:0]  FILT_MAX = FW'(FILT_CYCLES);
  localparam logic [SWW-1:0] SW_MAX   = SWW'(SW_DB_CYCLES);

  // Two-flop synchronisers for the three asynchronous pins
  logic aMeta_q, aSync_q, bMeta_q, bSync_q, swMeta_q, swSync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aMeta_q  <= 1'b0;
      aSync_q  <= 1'b0;
      bMeta_q  <= 1'b0;
      bSync_q  <= 1'b0;
      swMeta_q <= 1'b0;
      swSync_q <= 1'b0;
    end else begin
      aMeta_q  <= ina;
      aSync_q  <= aMeta_q;
      bMeta_q  <= inb;
      bSync_q  <= bMeta_q;
      swMeta_q <= sw;
      swSync_q <= swMeta_q;
    end
  end

  // Phase filters: a counter runs while the synchronised level disagrees
  // with the accepted level. Once it has reached FILT_CYCLES and the
  // disagreement is still present, the new level is accepted.
  logic [FW-1:0] aCnt_q, aCnt_d, bCnt_q, bCnt_d;
  logic          aAcc_q, aAcc_d, bAcc_q, bAcc_d;

  always_comb begin
    aCnt_d = aCnt_q;
    aAcc_d = aAcc_q;
    if (aSync_q == aAcc_q) begin
      aCnt_d = '0;
    end else if (aCnt_q >= FILT_MAX) begin
      aAcc_d = aSync_q;
      aCnt_d = '0;
    end else begin
      aCnt_d = aCnt_q + FW'(1);
    end
  end

  always_comb begin
    bCnt_d = bCnt_q;
    bAcc_d = bAcc_q;
    if (bSync_q == bAcc_q) begin
      bCnt_d = '0;
    end else if (bCnt_q >= FILT_MAX) begin
      bAcc_d = bSync_q;
      bCnt_d = '0;
    end else begin
      bCnt_d = bCnt_q + FW'(1);
    end
  end

  // Switch debounce: the same scheme as the phase filters, with a long
  // hold time. The counter saturates so it can never wrap back to zero.
  logic [SWW-1:0] swCnt_q, swCnt_d;
  logic           swAcc_q, swAcc_d;

  always_comb begin
    swCnt_d = swCnt_q;
    swAcc_d = swAcc_q;
    if (swSync_q == swAcc_q) begin
      swCnt_d = '0;
    end else if (swCnt_q >= SW_MAX) begin
      swAcc_d = swSync_q;
      swCnt_d = '0;
    end else if (swCnt_q != {SWW{1'b1}}) begin
      swCnt_d = swCnt_q + SWW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aCnt_q  <= '0;
      aAcc_q  <= 1'b0;
      bCnt_q  <= '0;
      bAcc_q  <= 1'b0;
      swCnt_q <= '0;
      swAcc_q <= 1'b0;
    end else begin
      aCnt_q  <= aCnt_d;
      aAcc_q  <= aAcc_d;
      bCnt_q  <= bCnt_d;
      bAcc_q  <= bAcc_d;
      swCnt_q <= swCnt_d;
      swAcc_q <= swAcc_d;
    end
  end

  // Decoder. The Gray-coded state {A,B} is mapped to a position on the
  // forward cycle 00,10,11,01 (pos[1] = B, pos[0] = A^B). The positional
  // difference modulo 4 classifies the step:
  //   1 -> forward, 3 -> reverse, 2 -> illegal (both bits moved), 0 -> idle.
  logic [1:0] prev_q, prev_d;
  logic       cnt_q, cnt_d, dir_q, dir_d;
  logic [1:0] posCur, posPrev, posDiff;

  always_comb begin
    posCur  = {bAcc_q, aAcc_q ^ bAcc_q};
    posPrev = {prev_q[0], prev_q[1] ^ prev_q[0]};
    posDiff = posCur - posPrev;
    prev_d  = {aAcc_q, bAcc_q};
    cnt_d   = 1'b0;
    dir_d   = dir_q;
    if (posDiff == 2'd1) begin
      cnt_d = 1'b1;
      dir_d = 1'b1;
    end else if (posDiff == 2'd3) begin
      cnt_d = 1'b1;
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      cnt_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
    end
  end

  assign cnt    = cnt_q;
  assign dir    = dir_q;
  assign sw_out = swAcc_q;

endmodule

// File: tb/tb_quad_encoder.sv
// tb_quad_encoder
// Directed and randomised stimulus for quad_encoder. The reference model
// works at the level of encoder positions and pin-sample history:
// - Each clean phase edge schedules a count pulse FILT+3 clocks after the
//   first clock edge that samples it. The pulse direction comes from the
//   step between positions on the forward cycle.
// - sw_out follows a level once the pin has shown that level for
//   SW_DB+1 consecutive samples, delayed by the synchroniser.
module tb_quad_encoder;

  localparam int FILT  = 3;
  localparam int SW_DB = 8;

  logic clk = 1'b0;
  logic rst_n, ina, inb, sw;
  logic sw_out, dir, cnt;

  quad_encoder #(.FILT_CYCLES(FILT), .SW_DB_CYCLES(SW_DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ina   (ina),
    .inb   (inb),
    .sw    (sw),
    .sw_out(sw_out),
    .dir   (dir),
    .cnt   (cnt)
  );

  always #10 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   qCyc[$];
  logic qDir[$];
  logic hist[$];
  logic expDir = 1'b0;
  logic expSw = 1'b0;
  logic expCnt = 1'b0;
  logic prevSwOut = 1'b0;
  int   lastRise = -1;
  int   riseCount = 0;
  logic [1:0] st = 2'b00;

  // Position of state {A,B} on the forward rotation 00 -> 10 -> 11 -> 01
  function automatic int posOf(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] stateOf(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Advance one clock, update the model and compare every output
  task automatic stepClk();
    bit allSame;
    int n;
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      qCyc.delete();
      qDir.delete();
      hist.delete();
      expDir = 1'b0;
      expSw  = 1'b0;
    end else begin
      hist.push_back(sw);
    end
    n = hist.size();
    if (n >= 11) begin
      allSame = 1'b1;
      for (int i = n - 11; i <= n - 3; i++)
        if (hist[i] !== hist[n-11]) allSame = 1'b0;
      if (allSame) expSw = hist[n-11];
    end
    expCnt = 1'b0;
    if (qCyc.size() > 0 && qCyc[0] == cycle) begin
      expCnt = 1'b1;
      expDir = qDir[0];
      void'(qCyc.pop_front());
      void'(qDir.pop_front());
    end
    #1;
    total++;
    assert (cnt === expCnt) else begin
      bad++;
      $error("FAIL cnt cycle=%0d observed=%0b expected=%0b", cycle, cnt, expCnt);
    end
    total++;
    assert (dir === expDir) else begin
      bad++;
      $error("FAIL dir cycle=%0d observed=%0b expected=%0b", cycle, dir, expDir);
    end
    total++;
    assert (sw_out === expSw) else begin
      bad++;
      $error("FAIL sw_out cycle=%0d observed=%0b expected=%0b", cycle, sw_out, expSw);
    end
    if (sw_out === 1'b1 && prevSwOut === 1'b0) begin
      lastRise = cycle;
      riseCount++;
    end
    prevSwOut = sw_out;
  endtask

  // Drive both phases to a new state and schedule the expected step
  task automatic driveAB(input logic a, input logic b, input int dwell);
    int d;
    ina = a;
    inb = b;
    d = (posOf({a, b}) - posOf(st) + 4) % 4;
    if (d == 1) begin
      qCyc.push_back(cycle + 1 + FILT + 3);
      qDir.push_back(1'b1);
    end else if (d == 3) begin
      qCyc.push_back(cycle + 1 + FILT + 3);
      qDir.push_back(1'b0);
    end
    st = {a, b};
    repeat (dwell) stepClk();
  endtask

  initial begin
    int p;
    int steadyStart;

    // Reset with all pins high: every output must stay cleared
    rst_n = 1'b0;
    ina = 1'b1;
    inb = 1'b1;
    sw = 1'b1;
    #1;
    total++;
    assert ({sw_out, dir, cnt} === 3'b000) else begin
      bad++;
      $error("FAIL reset_outputs observed=%b expected=000", {sw_out, dir, cnt});
    end
    repeat (3) stepClk();
    ina = 1'b0;
    inb = 1'b0;
    sw = 1'b0;
    stepClk();
    rst_n = 1'b1;
    st = 2'b00;
    repeat (12) stepClk();

    // Full forward rotation, then a full reverse rotation, 5-clock dwell
    driveAB(1'b1, 1'b0, 5);
    driveAB(1'b1, 1'b1, 5);
    driveAB(1'b0, 1'b1, 5);
    driveAB(1'b0, 1'b0, 5);
    repeat (10) stepClk();
    driveAB(1'b0, 1'b1, 5);
    driveAB(1'b1, 1'b1, 5);
    driveAB(1'b1, 1'b0, 5);
    driveAB(1'b0, 1'b0, 5);
    repeat (10) stepClk();

    // A 2-clock glitch on A is rejected; a 4-clock pulse gives two steps
    ina = 1'b1;
    repeat (2) stepClk();
    ina = 1'b0;
    repeat (12) stepClk();
    driveAB(1'b1, 1'b0, 4);
    driveAB(1'b0, 1'b0, 12);

    // Both phases move together: no step, then a legal 11->01 step
    driveAB(1'b1, 1'b1, 8);
    driveAB(1'b0, 1'b1, 8);
    driveAB(1'b0, 1'b0, 10);

    // Random walk of legal steps with random dwell
    p = 0;
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) p = p + 1;
      else p = p + 3;
      driveAB(stateOf(p)[1], stateOf(p)[0], int'($urandom_range(5, 9)));
    end
    repeat (10) stepClk();

    // Reset in the middle of a pending edge: that edge must never count
    driveAB(~st[1], st[0], 3);
    rst_n = 1'b0;
    ina = 1'b0;
    inb = 1'b0;
    st = 2'b00;
    #1;
    total++;
    assert ({dir, cnt} === 2'b00) else begin
      bad++;
      $error("FAIL midstep_reset observed=%b expected=00", {dir, cnt});
    end
    repeat (2) stepClk();
    rst_n = 1'b1;
    repeat (14) stepClk();

    // Switch bounce never reaches sw_out; a steady press and release do
    repeat (4) begin
      sw = 1'b1;
      repeat (3) stepClk();
      sw = 1'b0;
      repeat (2) stepClk();
    end
    riseCount = 0;
    sw = 1'b1;
    steadyStart = cycle + 1;
    repeat (20) stepClk();
    total++;
    assert (lastRise === steadyStart + 2 + SW_DB) else begin
      bad++;
      $error("FAIL sw_rise_time observed=%0d expected=%0d", lastRise, steadyStart + 2 + SW_DB);
    end
    total++;
    assert (riseCount === 1) else begin
      bad++;
      $error("FAIL sw_rise_count observed=%0d expected=1", riseCount);
    end
    sw = 1'b0;
    repeat (20) stepClk();

    // Every scheduled step must have been consumed
    total++;
    assert (qCyc.size() === 0) else begin
      bad++;
      $error("FAIL pending_steps observed=%0d expected=0", qCyc.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder.md
Name: quad_encoder

Overview:
Front-end for a panel rotary encoder with integrated push switch. It synchronises and glitch-filters the two quadrature phases (ina, inb) and the switch (sw). It decodes every valid quadrature step into a one-clock count strobe plus a direction flag, and it delivers a debounced switch level. It sits between the board pins and the tuning/menu control logic, which consumes cnt/dir as step events.

Parameters:
FILT_CYCLES, 3, consecutive clocks a synchronised phase level must hold before it is accepted (1..15); must be below the shortest phase dwell (5 clocks at 50 MHz for 100 ns dwell).
SW_DB_CYCLES, 1000000, consecutive clocks sw must hold before sw_out follows (20 ms at 50 MHz); bench overrides to a small value, e.g. 8.

Ports:
clk  input  1  system clock, 50 MHz nominal, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
ina  input  1  encoder phase A, asynchronous pin.
inb  input  1  encoder phase B, asynchronous pin.
sw  input  1  encoder push switch, asynchronous pin, active-high.
sw_out  output  1  debounced switch level.
dir  output  1  direction of the most recent valid step: 1 = A leads B, 0 = B leads A.
cnt  output  1  one-clock strobe per valid quadrature step.

Behaviour:
- Reset (rst_n=0, async): all sync flops, filters, counters and outputs cleared. sw_out=0, dir=0, cnt=0. Filtered phase state = 00. On release, the first step is evaluated against state 00.
- Synchroniser: each of ina, inb and sw passes through a 2-flop synchroniser.
- Phase filter, independent per phase: a counter increments while the synchronised level differs from the accepted level and clears when it matches. When the counter reaches FILT_CYCLES, the accepted level takes the synchronised level and the counter clears. Pulses shorter than FILT_CYCLES clocks never reach the accepted level.
- Decoder: registers the previous accepted state {A,B}. Each clock it compares current and previous state:
  - Forward (dir<=1, cnt=1): 00->10, 10->11, 11->01, 01->00.
  - Reverse (dir<=0, cnt=1): 00->01, 01->11, 11->10, 10->00.
  - No change: cnt=0, dir holds.
  - Both bits change in the same clock (illegal): cnt=0, dir holds, the new state is still adopted as previous.
- cnt is registered and high for exactly one clock per step. dir is updated in the same clock cnt rises and holds until the next valid step.
- Latency: a clean input edge produces cnt exactly FILT_CYCLES+3 clocks after the first clk rising edge that samples the new pin level. The latency is identical for every step and both phases.
- Switch debounce: same scheme as the phase filter but using SW_DB_CYCLES. The counter must be wide enough for SW_DB_CYCLES and must saturate, never wrap.
- Reset asserted mid-step: any pending filter count is discarded and no cnt is emitted for the interrupted edge.

Test Plan:
- Reset: hold rst_n=0 with ina=inb=sw=1 -> sw_out=0, dir=0, cnt=0. Release with inputs at 0 -> no cnt pulses.
- Forward cycle, 100 ns (5-clock) dwell, sequence AB 00->10->11->01->00 -> exactly 4 single-clock cnt pulses, each FILT_CYCLES+3 clocks after its edge; dir=1 at each pulse and held afterwards.
- Reverse cycle, AB 00->01->11->10->00, 5-clock dwell -> exactly 4 cnt pulses with dir=0. dir falls with the first reverse pulse.
- Glitch: with FILT_CYCLES=3, a 2-clock high pulse on ina -> no cnt, dir unchanged. The same pulse held 4 clocks, then released -> 2 pulses, forward then reverse (dir 1 then 0).
- Illegal step: with the accepted state at 00, drive ina and inb high together -> no cnt and dir holds. A following 11->01 step -> 1 pulse with dir=1.
- Switch (SW_DB_CYCLES=8): sw bouncing 3 clocks high / 2 low for 20 clocks, then steady high -> sw_out rises once, 2+8 clocks after steady high starts. A steady release -> sw_out falls once.
